// File: rtl/mips_muldiv.sv
// Radix-2 iterative multiply/divide unit owning HI/LO for the MIPS EX stage.
// Optional build macro MDU_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_al, prod_fix;
  logic               early;
`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0]   rem_mask;
  logic [CNT_W:0]     sh_amt;
`endif

  // Shared datapath: operand magnitudes, one shift-add step, one restoring-divide step.
  always_comb begin
    sgn     = op[0];
    abs_a   = (sgn && a[WIDTH-1]) ? WIDTH'(-a) : a;
    abs_b   = (sgn && b[WIDTH-1]) ? WIDTH'(-b) : b;
    mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : (WIDTH+1)'(0));
    rem_sh  = {acc_q, mq_q[WIDTH-1]};
    div_ok  = (rem_sh >= {1'b0, dvs_q});
`ifdef MDU_EARLY_OUT_EN
    // Unprocessed multiplier bits sit in the low WIDTH-cnt positions of mq.
    rem_mask = {WIDTH{1'b1}} >> cnt_q;
    early    = !is_div_q && ((mq_q & rem_mask) == '0);
    sh_amt   = (CNT_W+1)'(WIDTH) - (CNT_W+1)'(cnt_q);
    prod_al  = {acc_q, mq_q} >> sh_amt;
`else
    early    = 1'b0;
    prod_al  = {acc_q, mq_q};
`endif
    prod_fix = neg_quot_q ? (2*WIDTH)'(-prod_al) : prod_al;
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    dvs_d      = dvs_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d    = S_CALC;
          is_div_d   = op[1];
          neg_quot_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = sgn && a[WIDTH-1];
          dz_d       = op[1] && (b == '0);
          dvs_d      = op[1] ? abs_b : abs_a;
          mq_d       = op[1] ? abs_a : abs_b;
          acc_d      = '0;
          cnt_d      = '0;
        end
      end
      S_CALC: begin
        if (early) begin
          state_d = S_FIX;
        end else begin
          if (!is_div_q) begin
            acc_d = mul_sum[WIDTH:1];
            mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
          end else if (div_ok) begin
            acc_d = WIDTH'(rem_sh - {1'b0, dvs_q});
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          // With a zero divisor the remainder holds |a|, so the sign fix restores raw a.
          hi_d = neg_rem_q ? WIDTH'(-acc_q) : acc_q;
          lo_d = dz_q ? {WIDTH{1'b1}} : (neg_quot_q ? WIDTH'(-mq_q) : mq_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      dvs_q      <= dvs_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
